// File: rtl/fir_package.sv
// Shared control/flag bundles for the FIR requantizer stage.
package fir_package;

    localparam int unsigned FirShiftWidth = 5;
    localparam int unsigned FirCntWidth   = 16;

    typedef struct packed {
        logic                     start;
        logic [FirShiftWidth-1:0] shift;
        logic [FirCntWidth-1:0]   len;
    } fir_requant_ctrl_t;

    typedef struct packed {
        logic                   done;
        logic [FirCntWidth-1:0] sat_cnt;
    } fir_requant_flags_t;

endpackage

// File: rtl/fir_requant_fifo.sv
// Two-entry output buffer; entry 0 is always the head presented downstream.
module fir_requant_fifo #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [1:0]       level_o
);

    logic [WIDTH-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
    logic [1:0]       level_q, level_d;
    logic             push, pop, wr_head;

    assign out_valid_o = (level_q != 2'd0);
    assign out_data_o  = mem0_q;
    assign level_o     = level_q;
    assign push        = in_valid_i && (level_q != 2'd2);
    assign pop         = out_valid_o && out_ready_i;
    // New data lands in the head slot if the head is empty after this cycle's pop.
    assign wr_head     = (level_q == 2'd0) || ((level_q == 2'd1) && pop);

    always_comb begin
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        level_d = level_q;
        if (clear_i) begin
            mem0_d  = '0;
            mem1_d  = '0;
            level_d = 2'd0;
        end else begin
            if (pop) begin
                mem0_d = mem1_q;
            end
            if (push) begin
                if (wr_head) begin
                    mem0_d = in_data_i;
                end else begin
                    mem1_d = in_data_i;
                end
            end
            level_d = level_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem0_q  <= '0;
            mem1_q  <= '0;
            level_q <= 2'd0;
        end else begin
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/fir_requant.sv
// Requantizes FIR accumulator samples (round-half-up, shift, saturate) for one job of len samples.
module fir_requant
    import fir_package::*;
#(
    parameter int unsigned IN_WIDTH  = 40,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [4:0]           shift_i,
    input  logic [CNT_WIDTH-1:0] len_i,
    input  logic [IN_WIDTH-1:0]  in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [OUT_WIDTH-1:0] out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 done_o,
    output logic [CNT_WIDTH-1:0] sat_cnt_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic signed [IN_WIDTH:0] SatMax =
        {{(IN_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] SatMin =
        {{(IN_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    state_e                 state_q, state_d;
    logic [4:0]             shift_q, shift_d;
    logic [CNT_WIDTH-1:0]   len_q, len_d;
    logic [CNT_WIDTH-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_WIDTH-1:0]   out_cnt_q, out_cnt_d;
    logic [CNT_WIDTH-1:0]   sat_cnt_q, sat_cnt_d;

    fir_requant_ctrl_t      ctrl;
    fir_requant_flags_t     flags;

    logic                   in_gate, in_fire, out_fire, sat;
    logic [1:0]             fifo_level;
    logic signed [IN_WIDTH:0] ext, rnd, sum, shifted;
    logic [OUT_WIDTH-1:0]   req_data;

    assign ctrl = '{start: start_i, shift: shift_i, len: FirCntWidth'(len_i)};

    // Extra MSB keeps the rounding add from overflowing.
    always_comb begin
        ext = {in_data_i[IN_WIDTH-1], in_data_i};
        rnd = '0;
        if (shift_q != 5'd0) begin
            rnd = (IN_WIDTH + 1)'(1) << (shift_q - 5'd1);
        end
        sum     = ext + rnd;
        shifted = sum >>> shift_q;
        sat     = 1'b0;
        if (shifted > SatMax) begin
            req_data = SatMax[OUT_WIDTH-1:0];
            sat      = 1'b1;
        end else if (shifted < SatMin) begin
            req_data = SatMin[OUT_WIDTH-1:0];
            sat      = 1'b1;
        end else begin
            req_data = shifted[OUT_WIDTH-1:0];
        end
    end

    assign in_gate    = (state_q == StRun) && (in_cnt_q < len_q);
    assign in_ready_o = in_gate && (fifo_level != 2'd2);
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = out_valid_o && out_ready_i;

    fir_requant_fifo #(
        .WIDTH (OUT_WIDTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .in_data_i   (req_data),
        .in_valid_i  (in_fire),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .level_o     (fifo_level)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        len_d     = len_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        sat_cnt_d = sat_cnt_q;
        if (clear_i) begin
            state_d   = StIdle;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            sat_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ctrl.start) begin
                        shift_d   = ctrl.shift;
                        len_d     = CNT_WIDTH'(ctrl.len);
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                        sat_cnt_d = '0;
                        state_d   = (ctrl.len == '0) ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (in_fire) begin
                        in_cnt_d = in_cnt_q + 1'b1;
                        if (sat && (sat_cnt_q != '1)) begin
                            sat_cnt_d = sat_cnt_q + 1'b1;
                        end
                    end
                    if (out_fire) begin
                        out_cnt_d = out_cnt_q + 1'b1;
                        if (out_cnt_d == len_q) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            len_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            sat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            len_q     <= len_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign flags     = '{done: (state_q == StDone), sat_cnt: FirCntWidth'(sat_cnt_q)};
    assign done_o    = flags.done;
    assign sat_cnt_o = CNT_WIDTH'(flags.sat_cnt);

endmodule

// File: doc/fir_requant.md
FIR_REQUANT -- requirements
Module: fir_requant

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 40, meaning the signed accumulator width of the y samples produced by the FIR datapath.
REQ-002 SHALL have parameter OUT_WIDTH, default 16, meaning the signed output sample width (matches DATA_WIDTH).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, meaning the width of the length and saturation counters.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port clear_i, input, 1 bit: synchronous soft clear from the FIR controller.
REQ-007 SHALL have port start_i, input, 1 bit: single-cycle job start pulse.
REQ-008 SHALL have port shift_i, input, 5 bits: right-shift amount, latched on start.
REQ-009 SHALL have port len_i, input, CNT_WIDTH bits: number of samples in the job, latched on start.
REQ-010 SHALL have ports in_data_i (IN_WIDTH bits, input), in_valid_i (1, input) and in_ready_o (1, output): the upstream y stream from the datapath.
REQ-011 SHALL have ports out_data_o (OUT_WIDTH bits, output), out_valid_o (1, output) and out_ready_i (1, input): the downstream stream to the streamer sink.
REQ-012 SHALL have ports done_o (1, output), a one-cycle pulse at job end, and sat_cnt_o (CNT_WIDTH, output), the number of saturated samples in the current/last job.

Function
REQ-013 SHALL use an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL leave IDLE on start_i: it latches shift_i and len_i, zeroes the counters, and goes to RUN, or to DONE if len_i==0.
REQ-015 SHALL count only samples with an out_valid_o&&out_ready_i handshake, and SHALL go RUN->DONE on the handshake that makes the count equal len.
REQ-016 SHALL assert done_o for exactly one cycle in DONE and then return to IDLE.
REQ-017 SHALL accept an input only when in_valid_i&&in_ready_o; in_ready_o=1 only in RUN, while the output buffer is not full and accepted inputs < len.
REQ-018 SHALL transfer data unchanged except for requantization: round-half-up (add 2^(shift-1) when shift>0), arithmetic shift right by shift, computed in IN_WIDTH+1 bits so the rounding add cannot overflow.
REQ-019 SHALL saturate the result to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and increment sat_cnt_o per saturated accepted sample, holding at its maximum value instead of wrapping.
REQ-020 SHALL register results into a 2-entry FIFO; an input accepted in cycle t SHALL appear on out_valid_o in cycle t+1 when the FIFO is empty.
REQ-021 SHALL sustain one sample per cycle with out_ready_i held high, and SHALL keep out_data_o stable while out_valid_o&&!out_ready_i.
REQ-022 SHALL, on a simultaneous push and pop with the FIFO full, accept neither push; in_ready_o is derived from the registered FIFO level only.
REQ-023 SHALL ignore start_i outside IDLE.
REQ-024 SHALL, on clear_i, flush the FIFO, zero the counters and go to IDLE without asserting done_o; clear_i takes priority over start_i and over any handshake in the same cycle.

Reset
REQ-025 SHALL, on rst_i, go to IDLE immediately with in_ready_o=0, out_valid_o=0, out_data_o=0, done_o=0, sat_cnt_o=0, the latched shift/len=0 and the FIFO empty; reset mid-job SHALL discard all data in flight.

Structure
REQ-026 SHALL take fir_requant_ctrl_t (start, shift, len) and fir_requant_flags_t (done, sat_cnt) as typedefs from fir_package, with the FSM state enum local to the module.
REQ-027 SHALL implement the 2-entry buffer as sub-module fir_requant_fifo (data, valid/ready, clear, level); rounding and saturation stay combinational in fir_requant.

Verification
REQ-028 SHALL verify: shift=4, len=3, inputs 40'd24, 40'd23, -40'd24, ready high -> outputs 2, 1, -1 (the last because -1.5 rounds up), done_o one pulse after the 3rd handshake, sat_cnt_o=0.
REQ-029 SHALL verify: shift=0, inputs 40'd40000 and -40'd40000 -> outputs 32767 and -32768, sat_cnt_o=2.
REQ-030 SHALL verify: len=8 with out_ready_i toggling 1,0,0,1,... -> exactly 8 outputs in order, no duplicates or drops, in_ready_o=0 while the FIFO holds 2 entries.
REQ-031 SHALL verify: start with len=0 -> done_o pulses within 2 cycles, no out_valid_o.
REQ-032 SHALL verify: clear_i after 3 of 10 samples -> out_valid_o=0 the next cycle, FSM in IDLE, no done_o; a following job with len=2 completes normally.
REQ-033 SHALL verify: rst_i asserted asynchronously mid-job between clock edges -> all outputs 0 before the next edge.
